qq_cmd_sequencer: RTL and testbench

QQ_CMD_SEQUENCER -- requirements
Module: qq_cmd_sequencer

---
 rtl/qq_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_qq_cmd_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qq_cmd_sequencer.sv
// qq_cmd_sequencer: accepts one enqueue/dequeue command at a time, pulses the
// external queue node, waits SETTLE cycles for the node output to settle and
// returns a response. Occupancy is tracked locally against a capacity that is
// latched when each command is accepted.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op, cmd_data              0 = enqueue cmd_data, 1 = dequeue
//   array_size                    queue capacity, sampled on acceptance
//   q_enq, q_deq, q_data_o        one-cycle pulse and data to the queue node
//   q_data_i                      dequeued value from the queue node
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             dequeued value / rejection flag
//   count, full, empty            occupancy status
module qq_cmd_sequencer #(
  parameter int unsigned W      = 32,
  parameter int unsigned SETTLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [W-1:0] cmd_data,
  input  logic [7:0]   array_size,
  output logic         q_enq,
  output logic         q_deq,
  output logic [W-1:0] q_data_o,
  input  logic [W-1:0] q_data_i,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [7:0]   count,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] size_q, size_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic          accept_c;
  logic          reject_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      data_q     <= '0;
      size_q     <= '0;
      wait_q     <= '0;
      count_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      data_q     <= data_d;
      size_q     <= size_d;
      wait_q     <= wait_d;
      count_q    <= count_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign accept_c = cmd_valid && cmd_ready;
  // Guard uses the capacity being offered now, since that is what gets latched
  assign reject_c = cmd_op ? (count_q == '0) : (count_q >= array_size);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    size_d     = size_q;
    wait_d     = wait_q;
    count_d    = count_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          op_d       = cmd_op;
          data_d     = cmd_data;
          size_d     = array_size;
          rsp_data_d = '0;
          if (reject_c) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_d  = SETTLE_M1;
        count_d = op_q ? CW'(count_q - 8'd1) : CW'(count_q + 8'd1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          rsp_data_d = op_q ? q_data_i : '0;
          state_d    = S_RESP;
        end else begin
          wait_d = CW'(wait_q - 8'd1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are state decodes, masked while rst is high so an aborted
  // command produces neither a node pulse nor a response in the reset cycle
  assign cmd_ready = !rst && (state_q == S_IDLE);
  assign q_enq     = !rst && (state_q == S_ISSUE) && !op_q;
  assign q_deq     = !rst && (state_q == S_ISSUE) && op_q;
  assign q_data_o  = (!rst && ((state_q == S_ISSUE) || (state_q == S_WAIT))) ? data_q : '0;
  assign rsp_valid = !rst && (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;
  assign full      = (count_q >= size_q);
  assign empty     = (count_q == '0);

endmodule

// File: tb/tb_qq_cmd_sequencer.sv
// Bench for qq_cmd_sequencer: a cycle-stamped transaction model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_qq_cmd_sequencer;

  localparam int W      = 32;
  localparam int SETTLE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_op = 1'b0;
  logic [W-1:0] cmd_data = '0;
  logic [7:0]   array_size = '0;
  logic         q_enq, q_deq;
  logic [W-1:0] q_data_o;
  logic [W-1:0] q_data_i = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic [7:0]   count;
  logic         full, empty;

  qq_cmd_sequencer #(.W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .array_size(array_size),
    .q_enq(q_enq), .q_deq(q_deq), .q_data_o(q_data_o), .q_data_i(q_data_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_enq   = 0;
  int n_deq   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Transaction model: one command in flight, described by its acceptance cycle
  int           cyc = 0;
  bit           armed = 0;
  bit           m_busy = 0, m_op = 0, m_err = 0;
  int           m_acc = 0, m_lat = 0, m_count = 0, m_size = 0;
  logic [W-1:0] m_data = '0, m_rsp = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 0;
      m_count = 0;
      m_size  = 0;
    end else begin
      if (m_busy && !m_err && cyc == m_acc + 1) m_count = m_count + (m_op ? -1 : 1);
      if (m_busy && !m_err && cyc == m_acc + SETTLE + 1) m_rsp = m_op ? q_data_i : '0;
      if (m_busy) begin
        if (cyc >= m_acc + m_lat && rsp_ready) m_busy = 0;
      end else if (cmd_valid) begin
        m_busy = 1;
        m_acc  = cyc;
        m_op   = cmd_op;
        m_data = cmd_data;
        m_size = int'(array_size);
        m_err  = cmd_op ? (m_count == 0) : (m_count >= int'(array_size));
        m_lat  = m_err ? 1 : SETTLE + 2;
        m_rsp  = '0;
      end
    end
    cyc++;
    armed = 1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      bit           live, legal, e_rv;
      logic [W-1:0] e_qd;
      live  = !rst && m_busy;
      legal = live && !m_err;
      e_rv  = live && (cyc >= m_acc + m_lat);
      e_qd  = (legal && cyc >= m_acc + 1 && cyc <= m_acc + SETTLE + 1) ? m_data : '0;
      chk("cmd_ready", cmd_ready, !rst && !m_busy);
      chk("q_enq", q_enq, legal && !m_op && cyc == m_acc + 1);
      chk("q_deq", q_deq, legal && m_op && cyc == m_acc + 1);
      chk("q_data_o", q_data_o, e_qd);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) begin
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_data", rsp_data, m_rsp);
      end
      chk("count", count, 8'(m_count));
      chk("full", full, m_count >= m_size);
      chk("empty", empty, m_count == 0);
      if (q_enq === 1'b1) n_enq++;
      if (q_deq === 1'b1) n_deq++;
    end
  end

  // Entered and left just after a rising edge; responds with rsp_ready as set
  task automatic do_cmd(input bit op, input logic [W-1:0] d, input logic [7:0] sz,
                        output int lat, output logic [W-1:0] rd, output logic re);
    int t;
    lat = -1; rd = 'x; re = 1'bx;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; array_size = sz;
    t = 0;
    do begin @(negedge clk); t++; end while (cmd_ready !== 1'b1 && t < 50);
    if (cmd_ready !== 1'b1) begin timeout("accept"); cmd_valid = 1'b0; return; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (rsp_valid !== 1'b1 && t < 50);
    if (rsp_valid !== 1'b1) begin timeout("response"); return; end
    lat = t; rd = rsp_data; re = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    int           lat, e0, d0, t;
    logic [W-1:0] rd;
    logic         re;
    bit           seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_full", full, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Dequeue on empty queue is rejected after one cycle
    d0 = n_deq;
    do_cmd(1, 32'h0, 8'd4, lat, rd, re);
    chk("deq_empty_lat", lat, 1);
    chk("deq_empty_err", re, 1);
    chk("deq_empty_data", rd, 0);
    chk("deq_empty_pulses", n_deq - d0, 0);
    chk("deq_empty_count", count, 0);

    // Enqueue 0x11 into capacity 4
    e0 = n_enq;
    do_cmd(0, 32'h11, 8'd4, lat, rd, re);
    chk("enq_lat", lat, 6);
    chk("enq_err", re, 0);
    chk("enq_data", rd, 0);
    chk("enq_pulses", n_enq - e0, 1);
    chk("enq_count", count, 1);

    // Drain it, node returns 0x1234
    q_data_i = 32'h1234;
    do_cmd(1, 32'h0, 8'd4, lat, rd, re);
    chk("deq1_data", rd, 32'h1234);
    chk("deq1_count", count, 0);

    // Enqueue 0x5 then dequeue with node output 0xAB
    do_cmd(0, 32'h5, 8'd4, lat, rd, re);
    q_data_i = 32'hAB;
    d0 = n_deq;
    do_cmd(1, 32'h0, 8'd4, lat, rd, re);
    chk("deq_lat", lat, 6);
    chk("deq_err", re, 0);
    chk("deq_data", rd, 32'hAB);
    chk("deq_pulses", n_deq - d0, 1);
    chk("deq_count", count, 0);
    chk("deq_empty", empty, 1);

    // Capacity 2: third enqueue rejected
    do_cmd(0, 32'h1, 8'd2, lat, rd, re);
    do_cmd(0, 32'h2, 8'd2, lat, rd, re);
    do_cmd(0, 32'h3, 8'd2, lat, rd, re);
    chk("full_err", re, 1);
    chk("full_lat", lat, 1);
    chk("full_count", count, 2);
    chk("full_flag", full, 1);
    do_cmd(1, 32'h0, 8'd2, lat, rd, re);
    do_cmd(1, 32'h0, 8'd2, lat, rd, re);
    chk("drain_count", count, 0);

    // Response stalled 5 cycles while another command is offered
    do_cmd(0, 32'h77, 8'd4, lat, rd, re);
    e0 = n_enq;
    rsp_ready = 1'b0;
    q_data_i = 32'hC3;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = '0; array_size = 8'd4;
    t = 0;
    do begin @(negedge clk); t++; end while (cmd_ready !== 1'b1 && t < 50);
    @(posedge clk); #1;
    cmd_op = 1'b0; cmd_data = 32'h99;
    t = 0;
    do begin @(negedge clk); t++; end while (rsp_valid !== 1'b1 && t < 50);
    if (rsp_valid !== 1'b1) timeout("stall_response");
    q_data_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 32'hC3);
      chk("stall_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_count", count, 0);
    chk("stall_no_enq", n_enq - e0, 0);

    // Reset during the second WAIT cycle aborts the command
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 32'h42; array_size = 8'd4;
    t = 0;
    do begin @(negedge clk); t++; end while (cmd_ready !== 1'b1 && t < 50);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_count", count, 0);
    chk("abort_valid", rsp_valid, 0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid === 1'b1) seen = 1; end
    chk("abort_no_rsp", seen, 0);
    @(posedge clk); #1;

    // Capacity 0 rejects everything
    do_cmd(0, 32'h9, 8'd0, lat, rd, re);
    chk("zero_enq_err", re, 1);
    chk("zero_full", full, 1);
    chk("zero_empty", empty, 1);
    do_cmd(1, 32'h0, 8'd0, lat, rd, re);
    chk("zero_deq_err", re, 1);
    chk("zero_count", count, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
